// File: rtl/hazard_ctrl_nstage_pkg.sv
// Shared trap-FSM state encoding and pipeline-register indices for the hazard controller.
package hazard_ctrl_nstage_pkg;

    typedef enum logic [1:0] {
        T_IDLE  = 2'd0,
        T_DRAIN = 2'd1,
        T_FLUSH = 2'd2
    } trap_state_t;

    localparam int IFID  = 0;
    localparam int IDEX  = 1;
    localparam int EXMEM = 2;
    localparam int MEMWB = 3;

endpackage

// File: rtl/hazard_ctrl_nstage_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
// One-cycle update latency, no backpressure (holds at all-ones instead of wrapping).
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && (r_q != '1)) begin
            r_q <= r_q + W'(1);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/hazard_ctrl_nstage.sv
// Per-register bubble/write-enable generation plus drain/flush trap sequencing and perf counters.
// Hazard outputs are combinational in-cycle; mem_ready=0 freezes every register and the trap FSM.
module hazard_ctrl_nstage
    import hazard_ctrl_nstage_pkg::*;
#(
    parameter int NSTAGES  = 5,
    parameter int BR_STAGE = 3,
    parameter int RW       = 5,
    parameter int CNT_W    = 32
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [RW-1:0]      ifid_rs1,
    input  logic [RW-1:0]      ifid_rs2,
    input  logic [RW-1:0]      idex_rd,
    input  logic               ifid_memread,
    input  logic               idex_memread,
    input  logic               idex_memwrite,
    input  logic               mem_ready,
    input  logic               jump_id,
    input  logic [NSTAGES-2:0] branch_inflight,
    input  logic               branch_taken,
    input  logic               syscall_req,
    input  logic               int_req,
    input  logic               flush_req,
    input  logic               clr_cnt,
    output logic [NSTAGES-2:0] bubble,
    output logic [NSTAGES-2:0] write,
    output logic               write_pc,
    output logic               trap_take,
    output logic               trap_waiting,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    localparam int NREG = NSTAGES - 1;
    // Every register younger than the resolving branch gets squashed.
    localparam logic [NREG-1:0] BR_MASK = NREG'((1 << BR_STAGE) - 1);

    trap_state_t     r_state;
    logic            r_src_int;

    logic            w_inflight;
    logic            w_ld_hazard;
    logic [NREG-1:0] w_bubble;
    logic [NREG-1:0] w_write;
    logic            w_write_pc;
    logic            w_trap_take;
    logic            w_stall_inc;
    logic            w_flush_inc;

    assign w_inflight  = |branch_inflight;
    // Load-use against x0 never needs a stall since x0 is never written.
    assign w_ld_hazard = (ifid_memread & idex_memwrite)
                       | (idex_memread & (idex_rd != '0)
                          & ((idex_rd == ifid_rs1) | (idex_rd == ifid_rs2)));

    always_comb begin
        w_bubble    = '0;
        w_write     = '1;
        w_write_pc  = 1'b1;
        w_trap_take = 1'b0;
        if (resetn) begin
            if (!mem_ready) begin
                w_write    = '0;
                w_write_pc = 1'b0;
            end else begin
                case (r_state)
                    T_IDLE: begin
                        if (branch_taken) begin
                            w_bubble = BR_MASK;
                        end else if (w_ld_hazard) begin
                            w_bubble[IDEX] = 1'b1;
                            w_write[IFID]  = 1'b0;
                            w_write_pc     = 1'b0;
                        end else if (jump_id || flush_req) begin
                            w_bubble[IFID] = 1'b1;
                        end
                    end
                    T_DRAIN: begin
                        if (branch_taken && !r_src_int) begin
                            w_bubble = BR_MASK;
                        end else begin
                            w_bubble       = branch_taken ? BR_MASK : '0;
                            w_bubble[IDEX] = 1'b1;
                            w_write[IFID]  = 1'b0;
                            w_write_pc     = 1'b0;
                        end
                    end
                    T_FLUSH: begin
                        w_bubble    = '1;
                        w_trap_take = 1'b1;
                    end
                    default: begin
                        w_bubble = '0;
                    end
                endcase
            end
        end
    end

    // A squashed syscall aborts the trap; an interrupt survives the branch and keeps draining.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state   <= T_IDLE;
            r_src_int <= 1'b0;
        end else if (mem_ready) begin
            case (r_state)
                T_IDLE: begin
                    if (!branch_taken && (int_req || syscall_req)) begin
                        r_src_int <= int_req;
                        r_state   <= w_inflight ? T_DRAIN : T_FLUSH;
                    end
                end
                T_DRAIN: begin
                    if (branch_taken && !r_src_int) begin
                        r_state <= T_IDLE;
                    end else if (!w_inflight) begin
                        r_state <= T_FLUSH;
                    end
                end
                T_FLUSH: r_state <= T_IDLE;
                default: r_state <= T_IDLE;
            endcase
        end
    end

    assign bubble       = w_bubble;
    assign write        = w_write;
    assign write_pc     = w_write_pc;
    assign trap_take    = w_trap_take;
    assign trap_waiting = mem_ready & ((r_state != T_IDLE) | syscall_req | int_req);

    assign w_stall_inc = ~w_write_pc;
    assign w_flush_inc = (branch_taken & mem_ready) | w_trap_take;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clock  (clock),
        .resetn (resetn),
        .inc    (w_stall_inc),
        .clr    (clr_cnt),
        .q      (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clock  (clock),
        .resetn (resetn),
        .inc    (w_flush_inc),
        .clr    (clr_cnt),
        .q      (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl_nstage.sv
// Table-driven and sequence checks of hazard_ctrl_nstage through an expected-output queue.
module tb_hazard_ctrl_nstage;

    localparam logic [8:0] C_IFMR = 9'b100000000;
    localparam logic [8:0] C_EXMR = 9'b010000000;
    localparam logic [8:0] C_EXMW = 9'b001000000;
    localparam logic [8:0] C_MR   = 9'b000100000;
    localparam logic [8:0] C_JMP  = 9'b000010000;
    localparam logic [8:0] C_BT   = 9'b000001000;
    localparam logic [8:0] C_SYS  = 9'b000000100;
    localparam logic [8:0] C_INT  = 9'b000000010;
    localparam logic [8:0] C_FL   = 9'b000000001;

    typedef struct {
        string      name;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [8:0] ctl;
        logic [3:0] infl;
        logic [10:0] exp;
    } vec_t;

    logic       clock;
    logic       resetn;
    logic [4:0] ifid_rs1, ifid_rs2, idex_rd;
    logic       ifid_memread, idex_memread, idex_memwrite, mem_ready, jump_id;
    logic [3:0] branch_inflight;
    logic       branch_taken, syscall_req, int_req, flush_req, clr_cnt;
    logic [3:0] bubble, write;
    logic       write_pc, trap_take, trap_waiting;
    logic [3:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    vec_t sb[$];
    vec_t tbl[14];

    hazard_ctrl_nstage #(.NSTAGES(5), .BR_STAGE(3), .RW(5), .CNT_W(4)) dut (
        .clock           (clock),
        .resetn          (resetn),
        .ifid_rs1        (ifid_rs1),
        .ifid_rs2        (ifid_rs2),
        .idex_rd         (idex_rd),
        .ifid_memread    (ifid_memread),
        .idex_memread    (idex_memread),
        .idex_memwrite   (idex_memwrite),
        .mem_ready       (mem_ready),
        .jump_id         (jump_id),
        .branch_inflight (branch_inflight),
        .branch_taken    (branch_taken),
        .syscall_req     (syscall_req),
        .int_req         (int_req),
        .flush_req       (flush_req),
        .clr_cnt         (clr_cnt),
        .bubble          (bubble),
        .write           (write),
        .write_pc        (write_pc),
        .trap_take       (trap_take),
        .trap_waiting    (trap_waiting),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [10:0] E(logic [3:0] b, logic [3:0] w, logic pc, logic tt, logic tw);
        return {b, w, pc, tt, tw};
    endfunction

    function automatic vec_t V(string n, logic [4:0] a, logic [4:0] b, logic [4:0] d,
                               logic [8:0] ctl, logic [3:0] infl, logic [10:0] e);
        vec_t v;
        v.name = n; v.rs1 = a; v.rs2 = b; v.rd = d;
        v.ctl = ctl; v.infl = infl; v.exp = e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, want);
    endtask

    task automatic drive(input vec_t v);
        ifid_rs1        = v.rs1;
        ifid_rs2        = v.rs2;
        idex_rd         = v.rd;
        {ifid_memread, idex_memread, idex_memwrite, mem_ready, jump_id,
         branch_taken, syscall_req, int_req, flush_req} = v.ctl;
        branch_inflight = v.infl;
    endtask

    task automatic cyc(input vec_t v, input logic clr);
        @(posedge clock);
        #1;
        drive(v);
        clr_cnt = clr;
        sb.push_back(v);
    endtask

    task automatic clear_counters();
        cyc(V("clr", 5'd0, 5'd0, 5'd0, C_MR, 4'd0, E(4'h0, 4'hF, 1'b1, 1'b0, 1'b0)), 1'b1);
        cyc(V("clr_done", 5'd0, 5'd0, 5'd0, C_MR, 4'd0, E(4'h0, 4'hF, 1'b1, 1'b0, 1'b0)), 1'b0);
    endtask

    always @(negedge clock) begin
        if (sb.size() != 0) begin
            vec_t v;
            v = sb.pop_front();
            chk(v.name, 32'({bubble, write, write_pc, trap_take, trap_waiting}), 32'(v.exp));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        automatic logic [10:0] IDLE = E(4'h0, 4'hF, 1'b1, 1'b0, 1'b0);
        automatic logic [10:0] STALL = E(4'b0010, 4'b1110, 1'b0, 1'b0, 1'b0);
        automatic logic [10:0] FRZ = E(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);

        tbl[0]  = V("idle",        5'd0, 5'd0, 5'd0, C_MR, 4'd0, IDLE);
        tbl[1]  = V("lu_rs2",      5'd0, 5'd5, 5'd5, C_MR | C_EXMR, 4'd0, STALL);
        tbl[2]  = V("lu_rs1",      5'd7, 5'd0, 5'd7, C_MR | C_EXMR, 4'd0, STALL);
        tbl[3]  = V("lu_x0",       5'd0, 5'd0, 5'd0, C_MR | C_EXMR, 4'd0, IDLE);
        tbl[4]  = V("lu_miss",     5'd3, 5'd4, 5'd5, C_MR | C_EXMR, 4'd0, IDLE);
        tbl[5]  = V("las",         5'd0, 5'd0, 5'd0, C_MR | C_IFMR | C_EXMW, 4'd0, STALL);
        tbl[6]  = V("jump",        5'd0, 5'd0, 5'd0, C_MR | C_JMP, 4'd0, E(4'b0001, 4'hF, 1'b1, 1'b0, 1'b0));
        tbl[7]  = V("flush_req",   5'd0, 5'd0, 5'd0, C_MR | C_FL, 4'd0, E(4'b0001, 4'hF, 1'b1, 1'b0, 1'b0));
        tbl[8]  = V("br_taken",    5'd0, 5'd0, 5'd0, C_MR | C_BT, 4'd0, E(4'b0111, 4'hF, 1'b1, 1'b0, 1'b0));
        tbl[9]  = V("br_over_lu",  5'd5, 5'd5, 5'd5, C_MR | C_BT | C_EXMR, 4'd0, E(4'b0111, 4'hF, 1'b1, 1'b0, 1'b0));
        tbl[10] = V("memwait",     5'd5, 5'd5, 5'd5, C_EXMR | C_BT, 4'd0, FRZ);
        tbl[11] = V("lu_over_jmp", 5'd0, 5'd5, 5'd5, C_MR | C_EXMR | C_JMP, 4'd0, STALL);
        tbl[12] = V("memwait_sys", 5'd0, 5'd0, 5'd0, C_SYS, 4'd0, FRZ);
        tbl[13] = V("store_only",  5'd0, 5'd0, 5'd0, C_MR | C_EXMW, 4'd0, IDLE);

        resetn  = 1'b0;
        clr_cnt = 1'b0;
        drive(V("init", 5'd0, 5'd0, 5'd0, C_BT, 4'd0, IDLE));
        cyc(V("rst_out", 5'd0, 5'd0, 5'd0, C_BT, 4'd0, IDLE), 1'b0);
        @(negedge clock);
        #1;
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
        drive(V("idle", 5'd0, 5'd0, 5'd0, C_MR, 4'd0, IDLE));
        resetn = 1'b1;

        for (int i = 0; i < 14; i++) cyc(tbl[i], 1'b0);
        cyc(V("post_table", 5'd0, 5'd0, 5'd0, C_MR, 4'd0, IDLE), 1'b0);
        chk("table_stall_cnt", 32'(stall_cnt), 32'd6);
        chk("table_flush_cnt", 32'(flush_cnt), 32'd2);
        clear_counters();
        chk("clr_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("clr_flush_cnt", 32'(flush_cnt), 32'd0);

        // Syscall with nothing in flight: trap on the next cycle.
        cyc(V("a_req",  5'd0, 5'd0, 5'd0, C_MR | C_SYS, 4'd0, E(4'h0, 4'hF, 1'b1, 1'b0, 1'b1)), 1'b0);
        cyc(V("a_take", 5'd0, 5'd0, 5'd0, C_MR | C_SYS, 4'd0, E(4'hF, 4'hF, 1'b1, 1'b1, 1'b1)), 1'b0);
        cyc(V("a_idle", 5'd0, 5'd0, 5'd0, C_MR, 4'd0, IDLE), 1'b0);
        chk("a_flush_cnt", 32'(flush_cnt), 32'd1);
        chk("a_stall_cnt", 32'(stall_cnt), 32'd0);
        clear_counters();

        // Syscall squashed by a taken branch while draining.
        cyc(V("b_req",   5'd0, 5'd0, 5'd0, C_MR | C_SYS, 4'b0010, E(4'h0, 4'hF, 1'b1, 1'b0, 1'b1)), 1'b0);
        cyc(V("b_drain", 5'd0, 5'd0, 5'd0, C_MR | C_SYS, 4'b0100, E(4'b0010, 4'b1110, 1'b0, 1'b0, 1'b1)), 1'b0);
        cyc(V("b_abort", 5'd0, 5'd0, 5'd0, C_MR | C_SYS | C_BT, 4'b1000, E(4'b0111, 4'hF, 1'b1, 1'b0, 1'b1)), 1'b0);
        cyc(V("b_idle",  5'd0, 5'd0, 5'd0, C_MR, 4'd0, IDLE), 1'b0);
        chk("b_flush_cnt", 32'(flush_cnt), 32'd1);
        chk("b_stall_cnt", 32'(stall_cnt), 32'd1);
        clear_counters();

        // Interrupt (with a simultaneous syscall) survives the taken branch.
        cyc(V("c_req",    5'd0, 5'd0, 5'd0, C_MR | C_INT | C_SYS, 4'b0010, E(4'h0, 4'hF, 1'b1, 1'b0, 1'b1)), 1'b0);
        cyc(V("c_drain",  5'd0, 5'd0, 5'd0, C_MR | C_INT | C_SYS, 4'b0100, E(4'b0010, 4'b1110, 1'b0, 1'b0, 1'b1)), 1'b0);
        cyc(V("c_branch", 5'd0, 5'd0, 5'd0, C_MR | C_INT | C_SYS | C_BT, 4'b1000, E(4'b0111, 4'b1110, 1'b0, 1'b0, 1'b1)), 1'b0);
        cyc(V("c_drain2", 5'd0, 5'd0, 5'd0, C_MR | C_INT | C_SYS, 4'b0000, E(4'b0010, 4'b1110, 1'b0, 1'b0, 1'b1)), 1'b0);
        cyc(V("c_take",   5'd0, 5'd0, 5'd0, C_MR | C_INT | C_SYS, 4'b0000, E(4'hF, 4'hF, 1'b1, 1'b1, 1'b1)), 1'b0);
        cyc(V("c_idle",   5'd0, 5'd0, 5'd0, C_MR, 4'd0, IDLE), 1'b0);
        chk("c_flush_cnt", 32'(flush_cnt), 32'd2);
        chk("c_stall_cnt", 32'(stall_cnt), 32'd3);
        clear_counters();

        // Memory wait while the flush is pending.
        cyc(V("d_req", 5'd0, 5'd0, 5'd0, C_MR | C_SYS, 4'd0, E(4'h0, 4'hF, 1'b1, 1'b0, 1'b1)), 1'b0);
        for (int i = 0; i < 3; i++) cyc(V("d_freeze", 5'd0, 5'd0, 5'd0, C_SYS, 4'd0, FRZ), 1'b0);
        cyc(V("d_take", 5'd0, 5'd0, 5'd0, C_MR | C_SYS, 4'd0, E(4'hF, 4'hF, 1'b1, 1'b1, 1'b1)), 1'b0);
        cyc(V("d_idle", 5'd0, 5'd0, 5'd0, C_MR, 4'd0, IDLE), 1'b0);
        chk("d_stall_cnt", 32'(stall_cnt), 32'd3);
        chk("d_flush_cnt", 32'(flush_cnt), 32'd1);

        // Asynchronous reset in the middle of a drain.
        cyc(V("e_req",   5'd0, 5'd0, 5'd0, C_MR | C_SYS, 4'b0010, E(4'h0, 4'hF, 1'b1, 1'b0, 1'b1)), 1'b0);
        cyc(V("e_drain", 5'd0, 5'd0, 5'd0, C_MR | C_SYS, 4'b0100, E(4'b0010, 4'b1110, 1'b0, 1'b0, 1'b1)), 1'b0);
        #6;
        resetn = 1'b0;
        drive(V("e_rst", 5'd0, 5'd0, 5'd0, C_BT | C_SYS, 4'b0100, IDLE));
        #1;
        chk("e_rst_out", 32'({bubble, write, write_pc, trap_take, trap_waiting}), 32'(IDLE));
        chk("e_rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("e_rst_flush_cnt", 32'(flush_cnt), 32'd0);
        drive(V("idle", 5'd0, 5'd0, 5'd0, C_MR, 4'd0, IDLE));
        #1;
        resetn = 1'b1;
        cyc(V("e_after", 5'd0, 5'd0, 5'd0, C_MR, 4'd0, IDLE), 1'b0);

        // Saturation, then clear winning over a simultaneous increment.
        clear_counters();
        for (int i = 0; i < 17; i++) cyc(V("f_wait", 5'd0, 5'd0, 5'd0, 9'd0, 4'd0, FRZ), 1'b0);
        cyc(V("f_idle", 5'd0, 5'd0, 5'd0, C_MR, 4'd0, IDLE), 1'b0);
        chk("f_stall_sat", 32'(stall_cnt), 32'd15);
        cyc(V("f_clr", 5'd0, 5'd0, 5'd0, 9'd0, 4'd0, FRZ), 1'b1);
        cyc(V("f_after", 5'd0, 5'd0, 5'd0, C_MR, 4'd0, IDLE), 1'b0);
        chk("f_stall_clr", 32'(stall_cnt), 32'd0);

        @(negedge clock);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_nstage.md
# hazard_ctrl_nstage

Parametrised successor to the ID-stage stall/bubble controller for the RiscY in-order pipeline. It generates per-pipeline-register bubble and write-enable vectors for any pipeline depth, and resolves memory, load-after-store and load-use hazards. Trap entry is sequenced by a registered drain/flush state machine, so traps are never taken over an unresolved branch. It also keeps saturating stall and flush performance counters for the CSR file.

## Interface
Parameters:
- `NSTAGES`, 5, pipeline stages. `NREG = NSTAGES-1` pipeline registers, index 0 = IF/ID.
- `BR_STAGE`, 3, register index where branches resolve (3 = EX/MEM→MEM). Must be 1..NREG-1.
- `RW`, 5, register-address width.
- `CNT_W`, 32, performance-counter width.

Ports:
- `clock` in 1: sole clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `ifid_rs1`, `ifid_rs2` in RW: source registers of the instruction in ID.
- `idex_rd` in RW: destination register in EX.
- `ifid_memread` in 1: instruction in ID is a load.
- `idex_memread`, `idex_memwrite` in 1: instruction in EX is a load / store.
- `mem_ready` in 1: 0 means a memory access is outstanding.
- `jump_id` in 1: jump or trap-return in ID.
- `branch_inflight` in NREG: bit i set means register i holds a branch.
- `branch_taken` in 1: branch at `BR_STAGE` is taken this cycle.
- `syscall_req` in 1: ecall/ebreak in ID.
- `int_req` in 1: level interrupt request, already masked.
- `flush_req` in 1: fence.i or CSR-side flush.
- `clr_cnt` in 1: synchronous clear of both counters.
- `bubble` out NREG: zero pipeline register i this edge.
- `write` out NREG: load enable for pipeline register i.
- `write_pc` out 1: PC load enable.
- `trap_take` out 1: PC mux selects the trap vector this cycle.
- `trap_waiting` out 1: a trap is pending.
- `stall_cnt` out CNT_W: count of cycles with `write_pc`=0.
- `flush_cnt` out CNT_W: count of taken branches plus traps.

## Operation
- Defaults: `bubble`=0, `write`=all 1, `write_pc`=1.
- Trap FSM states are T_IDLE, T_DRAIN and T_FLUSH. A `src_int` flag records the trap source.
- In T_IDLE, the combinational priority is, highest first:
  - `mem_ready`=0: all `write`=0, `write_pc`=0, no bubbles.
  - `branch_taken`: `bubble[0..BR_STAGE-1]`=1.
  - Load-after-store (`ifid_memread` & `idex_memwrite`): `bubble[1]`=1, `write[0]`=0, `write_pc`=0.
  - Load-use (`idex_memread` & `idex_rd`≠0 & `idex_rd` equals rs1 or rs2): same response as load-after-store. The x0 exclusion is new behaviour.
  - `jump_id` or `flush_req`: `bubble[0]`=1.
- T_IDLE transitions, evaluated only when `mem_ready`=1 and `branch_taken`=0:
  - `int_req` or `syscall_req` sets `src_int`=`int_req`; the interrupt wins over a simultaneous syscall.
  - Go to T_DRAIN if any `branch_inflight` bit is set, otherwise go to T_FLUSH.
- T_DRAIN:
  - Outputs: `write[0]`=0, `write_pc`=0, `bubble[1]`=1. Later registers flow normally.
  - `mem_ready`=0 freezes everything and the state holds.
  - If `branch_taken` and `src_int`=0: apply the branch bubbles, release the PC and abort to T_IDLE, because the syscall was squashed.
  - If `branch_taken` and `src_int`=1: apply the branch bubbles and stay in T_DRAIN.
  - When `branch_inflight`=0: go to T_FLUSH.
- T_FLUSH:
  - With `mem_ready`=1: `bubble`=all 1, `write_pc`=1, `trap_take`=1, then go to T_IDLE.
  - With `mem_ready`=0: freeze, `trap_take`=0, and hold state.
- `trap_waiting` = (state≠T_IDLE) | `syscall_req` | `int_req`. It is forced to 0 whenever `mem_ready`=0.
- Counters saturate at all-ones. `clr_cnt` has priority over any increment.
  - `stall_cnt` increments on every cycle with `write_pc`=0.
  - `flush_cnt` increments on every cycle with (`branch_taken` & `mem_ready`) or `trap_take`.

## Timing
- Reset (`resetn`=0, asynchronous) forces: state T_IDLE, `src_int`=0, both counters 0.
- Outputs during reset: `bubble`=0, `write`=all 1, `write_pc`=1, `trap_take`=0.
- A reset mid-drain discards the pending trap.
- All hazard outputs are combinational in the same cycle. `trap_take` is decoded from the state register gated only by `mem_ready`.
- Trap latency with no branch in flight: request in cycle n, then `trap_take` in cycle n+1.
- Trap latency with a branch in register i: `trap_take` no earlier than the cycle after the branch leaves `BR_STAGE`.
- `syscall_req` stays asserted through T_DRAIN because IF/ID is held. The FSM does not re-sample it.

## Structure
- FSM state encodings and the stage-index localparams (IFID=0, IDEX=1, …) go in `constants.vh`.
- Sub-module `sat_counter` (parameter `W`; ports `inc`, `clr`, `q`) is instantiated twice.
- Target size for the top level is about 200 lines.

## Test plan
- Load-use: `idex_memread`=1, `idex_rd`=5, `ifid_rs2`=5 → `bubble`=4'b0010, `write[0]`=0, `write_pc`=0, `stall_cnt` +1. Same stimulus with `idex_rd`=0 → no stall.
- Syscall, no branch in flight: `syscall_req`=1 at cycle 10 → `trap_take`=1 and `bubble`=4'b1111 at cycle 11, T_IDLE at cycle 12, `flush_cnt`=1.
- Syscall with `branch_inflight`=4'b0010 and the branch taken two cycles later → T_DRAIN, abort to T_IDLE, `trap_take` never asserted, `flush_cnt`=1.
- Interrupt, same branch scenario → the taken branch flushes and `trap_take` fires in the cycle after `branch_inflight` becomes 0. `flush_cnt`=2.
- `mem_ready`=0 for 3 cycles while in T_FLUSH → `write`=0, `trap_take`=0 for those cycles, then `trap_take`=1 on return. `stall_cnt`=3.
- `resetn` pulsed low mid-T_DRAIN → immediately T_IDLE with counters 0. `clr_cnt` with `stall_cnt` at all-ones → 0. Saturation holds at all-ones without wrap.
